// File: rtl/dmem_pkg.sv
// Shared definitions for the block-wide data memory behind the data cache:
// FSM state encoding, operation type and block geometry helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Default geometry: 4 words of 32 bits per block, 32-bit byte addresses.
  localparam int C_BLOCK_SIZE_DEF = 2;
  localparam int C_LINE_SIZE_DEF  = 32;
  localparam int ADDRESS_SIZE_DEF = 32;

  function automatic int words_per_block(input int c_block_size);
    return 1 << c_block_size;
  endfunction

  function automatic int block_width(input int c_block_size, input int c_line_size);
    return words_per_block(c_block_size) * c_line_size;
  endfunction

  // Block address drops the word-in-block bits and the byte-in-word bits.
  function automatic int block_addr_width(input int address_size, input int c_block_size);
    return address_size - c_block_size - 2;
  endfunction

  localparam int WORDS_PER_BLOCK = words_per_block(C_BLOCK_SIZE_DEF);
  localparam int BLOCK_W         = block_width(C_BLOCK_SIZE_DEF, C_LINE_SIZE_DEF);
  localparam int BA_W            = block_addr_width(ADDRESS_SIZE_DEF, C_BLOCK_SIZE_DEF);

endpackage

// File: rtl/dmem_backing_store_if.sv
// Cache-to-memory block bus: request side (read/write/address/write_data)
// driven by the cache, busywait/done/read_data returned by the memory.
interface dmem_backing_store_if #(
  parameter int BA_W  = 28,
  parameter int BLK_W = 128
) ();

  logic             read;
  logic             write;
  logic [BA_W-1:0]  address;
  logic [BLK_W-1:0] write_data;
  logic             busywait;
  logic [BLK_W-1:0] read_data;
  logic             read_done;
  logic             write_done;

  modport master (
    output read, write, address, write_data,
    input  busywait, read_data, read_done, write_done
  );

  modport slave (
    input  read, write, address, write_data,
    output busywait, read_data, read_done, write_done
  );

endinterface

// File: rtl/dmem_block_array.sv
// Block-wide synchronous storage with one write port and a registered
// read-out. The storage itself is never cleared; only the output register
// returns to zero on reset.
module dmem_block_array #(
  parameter int BLK_W = 128,
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [BLK_W-1:0] blk_i,
  output logic [BLK_W-1:0] blk_o
);

  logic [BLK_W-1:0] mem_q [DEPTH];
  logic [BLK_W-1:0] blk_q;

  // Block write into storage.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= blk_i;
    end
  end

  // Registered block read-out, held until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q <= '0;
    end else if (re_i) begin
      blk_q <= mem_q[idx_i];
    end
  end

  assign blk_o = blk_q;

endmodule

// File: rtl/dmem_backing_store.sv
// Multi-cycle block memory serving data-cache refills and write-backs.
// Each access takes a fixed MEM_LATENCY cycles from first sight of the
// request to the one-cycle done pulse. Request fields are captured when the
// access is accepted, so the cache may change them while it stalls.
// Optional build macro DMEM_ACCESS_COUNTERS_EN adds saturating 32-bit
// completed-read / completed-write counters as extra outputs.
module dmem_backing_store
  import dmem_pkg::*;
#(
  parameter int c_block_size     = 2,
  parameter int c_line_size      = 32,
  parameter int address_size     = 32,
  parameter int MEM_DEPTH_BLOCKS = 256,
  parameter int MEM_LATENCY      = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  dmem_backing_store_if.slave   bus
`ifdef DMEM_ACCESS_COUNTERS_EN
  ,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
`endif
);

  localparam int BLK_W  = block_width(c_block_size, c_line_size);
  localparam int IDX_W  = $clog2(MEM_DEPTH_BLOCKS);
  localparam int CNT_W  = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 2);

  generate
    if (MEM_LATENCY < 2) begin : g_bad_latency
      $error("dmem_backing_store: MEM_LATENCY must be 2 or more");
    end
    if ((1 << IDX_W) != MEM_DEPTH_BLOCKS) begin : g_bad_depth
      $error("dmem_backing_store: MEM_DEPTH_BLOCKS must be a power of two");
    end
  endgenerate

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  op_e              op_q;
  logic             rd_done_q;
  logic             wr_done_q;
  logic [IDX_W-1:0] idx_q;
  logic [BLK_W-1:0] wdata_q;

  logic accept;
  logic finish;
  logic arr_we;
  logic arr_re;

  // An access is taken from IDLE whenever either request is high; the last
  // BUSY edge (counter at zero) is where storage is touched.
  assign accept = (state_q == S_IDLE) && (bus.read || bus.write);
  assign finish = (state_q == S_BUSY) && (cnt_q == '0);
  assign arr_we = finish && (op_q == OP_WRITE);
  assign arr_re = finish && (op_q == OP_READ);

  // Access sequencer: IDLE -> BUSY (latency countdown) -> DONE -> IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_READ;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          rd_done_q <= 1'b0;
          wr_done_q <= 1'b0;
          if (accept) begin
            state_q <= S_BUSY;
            cnt_q   <= CNT_LOAD;
            // Write wins when both are raised; the read must be re-issued.
            op_q    <= bus.write ? OP_WRITE : OP_READ;
          end
        end
        S_BUSY: begin
          if (cnt_q == '0) begin
            state_q   <= S_DONE;
            rd_done_q <= (op_q == OP_READ);
            wr_done_q <= (op_q == OP_WRITE);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          // Requests seen here are not taken; they count from the next IDLE.
          state_q   <= S_IDLE;
          rd_done_q <= 1'b0;
          wr_done_q <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          rd_done_q <= 1'b0;
          wr_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Snapshot of the request fields at accept; upper address bits wrap away.
  always_ff @(posedge clock) begin
    if (accept) begin
      idx_q   <= bus.address[IDX_W-1:0];
      wdata_q <= bus.write_data;
    end
  end

  dmem_block_array #(
    .BLK_W (BLK_W),
    .DEPTH (MEM_DEPTH_BLOCKS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clock),
    .rst_n (reset),
    .we_i  (arr_we),
    .re_i  (arr_re),
    .idx_i (idx_q),
    .blk_i (wdata_q),
    .blk_o (bus.read_data)
  );

  assign bus.busywait   = accept || (state_q == S_BUSY);
  assign bus.read_done  = rd_done_q;
  assign bus.write_done = wr_done_q;

`ifdef DMEM_ACCESS_COUNTERS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  // Saturating increment on each completed access.
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (rd_done_q && (rd_count_q != 32'hFFFF_FFFF)) begin
      rd_count_d = rd_count_q + 32'd1;
    end
    if (wr_done_q && (wr_count_q != 32'hFFFF_FFFF)) begin
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_dmem_backing_store.sv
// Self-checking bench for dmem_backing_store: directed scenarios plus a
// randomized mix, all checked against a block-level reference memory.
module tb_dmem_backing_store;

  localparam int LAT   = 5;
  localparam int DEPTH = 256;
  localparam int BA_W  = 28;
  localparam int BLK_W = 128;

  logic clock;
  logic reset;

  dmem_backing_store_if #(.BA_W(BA_W), .BLK_W(BLK_W)) bus ();

`ifdef DMEM_ACCESS_COUNTERS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  dmem_backing_store #(
    .c_block_size     (2),
    .c_line_size      (32),
    .address_size     (32),
    .MEM_DEPTH_BLOCKS (DEPTH),
    .MEM_LATENCY      (LAT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus)
`ifdef DMEM_ACCESS_COUNTERS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference: storage keyed by block index, plus the last completed read.
  logic [BLK_W-1:0] model_mem [int];
  logic [BLK_W-1:0] model_rd;

  function automatic int idx_of(input logic [BA_W-1:0] a);
    return int'(a) % DEPTH;
  endfunction

  function automatic logic [BLK_W-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Issues one request and observes the whole access window.
  task automatic access(input bit rd, input bit wr, input logic [BA_W-1:0] a,
                        input logic [BLK_W-1:0] d, output int busy_n,
                        output int done_at, output int rd_p, output int wr_p,
                        output logic [BLK_W-1:0] rdata);
    @(negedge clock);
    bus.read = rd; bus.write = wr; bus.address = a; bus.write_data = d;
    #1;
    busy_n = int'(bus.busywait);
    done_at = -1; rd_p = 0; wr_p = 0; rdata = 'x;
    for (int k = 1; k <= LAT + 3; k++) begin
      @(posedge clock); #1;
      if (k == 1) begin
        bus.read = 1'b0; bus.write = 1'b0;
        bus.address = BA_W'($urandom); bus.write_data = rand_blk();
      end
      busy_n += int'(bus.busywait);
      if ((bus.read_done || bus.write_done) && done_at < 0) done_at = k;
      rd_p += int'(bus.read_done);
      wr_p += int'(bus.write_done);
      if (bus.read_done) rdata = bus.read_data;
    end
  endtask

  task automatic test_reset();
    bus.read = 0; bus.write = 0; bus.address = '0; bus.write_data = '0;
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++; if (bus.busywait !== 1'b0) begin bad++; $display("FAIL rst_busywait got=%b exp=0", bus.busywait); end
    total++; if (bus.read_done !== 1'b0) begin bad++; $display("FAIL rst_read_done got=%b exp=0", bus.read_done); end
    total++; if (bus.write_done !== 1'b0) begin bad++; $display("FAIL rst_write_done got=%b exp=0", bus.write_done); end
    total++; if (bus.read_data !== '0) begin bad++; $display("FAIL rst_read_data got=%h exp=0", bus.read_data); end
    reset = 1'b1;
    model_rd = '0;
    @(negedge clock); #1;
    total++; if (bus.busywait !== 1'b0) begin bad++; $display("FAIL rel_busywait got=%b exp=0", bus.busywait); end
  endtask

  task automatic test_write_read();
    int b, d, rp, wp;
    logic [BLK_W-1:0] rdat;
    logic [BLK_W-1:0] blk = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    access(0, 1, 28'h3, blk, b, d, rp, wp, rdat);
    model_mem[3] = blk;
    total++; if (b !== LAT) begin bad++; $display("FAIL wr_busy_cycles got=%0d exp=%0d", b, LAT); end
    total++; if (d !== LAT) begin bad++; $display("FAIL wr_latency got=%0d exp=%0d", d, LAT); end
    total++; if (wp !== 1 || rp !== 0) begin bad++; $display("FAIL wr_pulses got wr=%0d rd=%0d exp wr=1 rd=0", wp, rp); end
    access(1, 0, 28'h3, '0, b, d, rp, wp, rdat);
    model_rd = model_mem[3];
    total++; if (b !== LAT) begin bad++; $display("FAIL rd_busy_cycles got=%0d exp=%0d", b, LAT); end
    total++; if (d !== LAT) begin bad++; $display("FAIL rd_latency got=%0d exp=%0d", d, LAT); end
    total++; if (rp !== 1 || wp !== 0) begin bad++; $display("FAIL rd_pulses got rd=%0d wr=%0d exp rd=1 wr=0", rp, wp); end
    total++; if (rdat !== model_rd) begin bad++; $display("FAIL rd_data got=%h exp=%h", rdat, model_rd); end
    total++; if (bus.read_data !== model_rd) begin bad++; $display("FAIL rd_data_held got=%h exp=%h", bus.read_data, model_rd); end
  endtask

  task automatic test_wrap();
    int b, d, rp, wp;
    logic [BLK_W-1:0] rdat;
    logic [BLK_W-1:0] blk = rand_blk();
    access(0, 1, 28'h5, blk, b, d, rp, wp, rdat);
    model_mem[idx_of(28'h5)] = blk;
    access(1, 0, 28'h105, '0, b, d, rp, wp, rdat);
    model_rd = model_mem[idx_of(28'h105)];
    total++; if (rdat !== model_rd) begin bad++; $display("FAIL wrap_data got=%h exp=%h", rdat, model_rd); end
  endtask

  task automatic test_both_high();
    int b, d, rp, wp;
    logic [BLK_W-1:0] rdat;
    logic [BLK_W-1:0] blk = rand_blk();
    access(1, 1, 28'h7, blk, b, d, rp, wp, rdat);
    model_mem[7] = blk;
    total++; if (wp !== 1 || rp !== 0) begin bad++; $display("FAIL both_pulses got wr=%0d rd=%0d exp wr=1 rd=0", wp, rp); end
    total++; if (bus.read_data !== model_rd) begin bad++; $display("FAIL both_rd_held got=%h exp=%h", bus.read_data, model_rd); end
    access(1, 0, 28'h7, '0, b, d, rp, wp, rdat);
    model_rd = model_mem[7];
    total++; if (rdat !== model_rd) begin bad++; $display("FAIL both_readback got=%h exp=%h", rdat, model_rd); end
  endtask

  // Write held high across two accesses: DONE refuses it, next IDLE takes it.
  task automatic test_back_to_back();
    int dq[$];
    int busy_in_done;
    logic [BLK_W-1:0] blk = rand_blk();
    busy_in_done = 0;
    @(negedge clock);
    bus.write = 1; bus.read = 0; bus.address = 28'h20; bus.write_data = blk;
    for (int k = 1; k <= 2 * LAT + 4; k++) begin
      @(posedge clock); #1;
      if (bus.write_done) begin
        dq.push_back(k);
        busy_in_done += int'(bus.busywait);
      end
      if (k == LAT + 2) bus.write = 0;
    end
    model_mem[idx_of(28'h20)] = blk;
    total++; if (dq.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", dq.size()); end
    else begin
      total++; if (dq[0] !== LAT || dq[1] !== 2 * LAT + 1) begin
        bad++; $display("FAIL b2b_times got=%0d,%0d exp=%0d,%0d", dq[0], dq[1], LAT, 2 * LAT + 1);
      end
    end
    total++; if (busy_in_done !== 0) begin bad++; $display("FAIL b2b_busy_in_done got=%0d exp=0", busy_in_done); end
  endtask

  task automatic test_reset_mid();
    int b, d, rp, wp, stray;
    logic [BLK_W-1:0] rdat;
    @(negedge clock);
    bus.read = 1; bus.write = 0; bus.address = 28'h3;
    @(posedge clock); #1; bus.read = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    model_rd = '0;
    total++; if (bus.busywait !== 1'b0) begin bad++; $display("FAIL mid_busywait got=%b exp=0", bus.busywait); end
    total++; if (bus.read_done !== 1'b0) begin bad++; $display("FAIL mid_read_done got=%b exp=0", bus.read_done); end
    total++; if (bus.read_data !== model_rd) begin bad++; $display("FAIL mid_read_data got=%h exp=0", bus.read_data); end
    @(negedge clock); reset = 1'b1;
    stray = 0;
    repeat (LAT + 2) begin @(posedge clock); #1; stray += int'(bus.read_done); end
    total++; if (stray !== 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", stray); end
    access(1, 0, 28'h3, '0, b, d, rp, wp, rdat);
    model_rd = model_mem[3];
    total++; if (d !== LAT) begin bad++; $display("FAIL mid_relatency got=%0d exp=%0d", d, LAT); end
    total++; if (rdat !== model_rd) begin bad++; $display("FAIL mid_reread got=%h exp=%h", rdat, model_rd); end
  endtask

  task automatic test_random();
    int b, d, rp, wp;
    int written[$];
    logic [BLK_W-1:0] rdat, blk;
    logic [BA_W-1:0] a;
    bit rd, wr;
    foreach (model_mem[i]) written.push_back(i);
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 2))
        0: begin rd = 1; wr = 0; end
        1: begin rd = 0; wr = 1; end
        default: begin rd = 1; wr = 1; end
      endcase
      blk = rand_blk();
      if (wr) a = BA_W'($urandom);
      else a = BA_W'(($urandom << 8) | written[$urandom_range(0, written.size() - 1)]);
      access(rd, wr, a, blk, b, d, rp, wp, rdat);
      total++; if (d !== LAT) begin bad++; $display("FAIL rnd_latency n=%0d got=%0d exp=%0d", n, d, LAT); end
      total++; if (b !== LAT) begin bad++; $display("FAIL rnd_busy n=%0d got=%0d exp=%0d", n, b, LAT); end
      if (wr) begin
        model_mem[idx_of(a)] = blk;
        written.push_back(idx_of(a));
        total++; if (wp !== 1 || rp !== 0) begin bad++; $display("FAIL rnd_wr_pulse n=%0d got wr=%0d rd=%0d", n, wp, rp); end
        total++; if (bus.read_data !== model_rd) begin bad++; $display("FAIL rnd_held n=%0d got=%h exp=%h", n, bus.read_data, model_rd); end
      end else begin
        model_rd = model_mem[idx_of(a)];
        total++; if (rp !== 1 || wp !== 0) begin bad++; $display("FAIL rnd_rd_pulse n=%0d got rd=%0d wr=%0d", n, rp, wp); end
        total++; if (rdat !== model_rd) begin bad++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, rdat, model_rd); end
      end
    end
  endtask

`ifdef DMEM_ACCESS_COUNTERS_EN
  task automatic test_counters();
    int b, d, rp, wp;
    logic [BLK_W-1:0] rdat;
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    model_rd = '0;
    total++; if (rd_count !== 32'd0 || wr_count !== 32'd0) begin bad++; $display("FAIL cnt_reset got rd=%0d wr=%0d exp 0", rd_count, wr_count); end
    for (int i = 0; i < 3; i++) begin
      access(0, 1, BA_W'(8'h40 + i), rand_blk(), b, d, rp, wp, rdat);
    end
    for (int i = 0; i < 2; i++) begin
      access(1, 0, 28'h3, '0, b, d, rp, wp, rdat);
    end
    total++; if (wr_count !== 32'd3) begin bad++; $display("FAIL cnt_wr got=%0d exp=3", wr_count); end
    total++; if (rd_count !== 32'd2) begin bad++; $display("FAIL cnt_rd got=%0d exp=2", rd_count); end
    @(negedge clock);
    force dut.rd_count_q = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.rd_count_q;
    access(1, 0, 28'h3, '0, b, d, rp, wp, rdat);
    total++; if (rd_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cnt_sat got=%h exp=ffffffff", rd_count); end
    total++; if (wr_count !== 32'd3) begin bad++; $display("FAIL cnt_wr_hold got=%0d exp=3", wr_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_both_high();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef DMEM_ACCESS_COUNTERS_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
